// File: rtl/config_readback_tx.sv
// Streams a snapshot of the imaging configuration as a byte frame over a valid/ready link.
// Define CONFIG_READBACK_CHECKSUM_EN to append a mod-256 checksum of bytes 1-22.
module config_readback_tx (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   channel_select,
  input  logic [4:0]   aline_select,
  input  logic [31:0]  pulse_shape,
  input  logic [127:0] delays,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

`ifdef CONFIG_READBACK_CHECKSUM_EN
  localparam logic [4:0] LAST_IDX = 5'd23;
`else
  localparam logic [4:0] LAST_IDX = 5'd22;
`endif
  localparam logic [7:0] HEADER = 8'hA5;

  state_t         r_state;
  logic [4:0]     r_idx;
  logic [175:0]   r_payload;
  logic [7:0]     r_tx_data;
  logic           r_tx_valid;
  logic           r_busy;
  logic           r_done;
`ifdef CONFIG_READBACK_CHECKSUM_EN
  logic [7:0]     r_csum;
`endif

  logic [127:0]   w_delays_msb;
  logic [175:0]   w_payload;
  logic           w_accept;

  // Channel 0 goes first on the wire, so it is moved to the top of the shift image.
  always_comb begin
    w_delays_msb = '0;
    for (int c = 0; c < 8; c++) begin
      w_delays_msb[127 - 16*c -: 16] = delays[16*c +: 16];
    end
  end

  assign w_payload = {channel_select, 3'b000, aline_select, pulse_shape, w_delays_msb};
  assign w_accept  = r_tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_payload  <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef CONFIG_READBACK_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_payload  <= w_payload;
            r_idx      <= '0;
            r_tx_data  <= HEADER;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= SEND;
`ifdef CONFIG_READBACK_CHECKSUM_EN
            r_csum     <= '0;
`endif
          end
        end
        SEND: begin
          if (w_accept) begin
            r_idx <= r_idx + 5'd1;
            if (r_idx == LAST_IDX) begin
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_payload <= {r_payload[167:0], 8'h00};
`ifdef CONFIG_READBACK_CHECKSUM_EN
              if (r_idx != 5'd0) r_csum <= r_csum + r_tx_data;
              // Byte 22 is being accepted: fold it into the running sum for the trailer.
              if (r_idx == 5'd22) r_tx_data <= r_csum + r_tx_data;
              else                r_tx_data <= r_payload[175:168];
`else
              r_tx_data <= r_payload[175:168];
`endif
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_idx   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_config_readback_tx.sv
// Randomized bench for config_readback_tx against a queue-based frame model.
// Honors CONFIG_READBACK_CHECKSUM_EN the same way the design does.
module tb_config_readback_tx;

  typedef logic [7:0] byte_q_t[$];

`ifdef CONFIG_READBACK_CHECKSUM_EN
  localparam int FRAME_LEN = 24;
`else
  localparam int FRAME_LEN = 23;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   channel_select = '0;
  logic [4:0]   aline_select = '0;
  logic [31:0]  pulse_shape = '0;
  logic [127:0] delays = '0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         busy;
  logic         done;

  config_readback_tx dut (
    .clk(clk), .rst(rst), .start(start),
    .channel_select(channel_select), .aline_select(aline_select),
    .pulse_shape(pulse_shape), .delays(delays),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int      checks = 0;
  int      errors = 0;
  bit      chk_en = 0;
  byte_q_t m_q;
  bit      m_active = 0;
  bit      m_done = 0;
  bit      m_was_done = 0;
  byte_q_t rx_log;
  int      done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic byte_q_t build_frame(input logic [7:0] ch, input logic [4:0] al,
                                          input logic [31:0] ps, input logic [127:0] dl);
    byte_q_t f;
    f.push_back(8'hA5);
    f.push_back(ch);
    f.push_back({3'b000, al});
    for (int i = 3; i >= 0; i--) f.push_back(ps[8*i +: 8]);
    for (int c = 0; c < 8; c++) begin
      f.push_back(dl[16*c + 8 +: 8]);
      f.push_back(dl[16*c +: 8]);
    end
`ifdef CONFIG_READBACK_CHECKSUM_EN
    begin
      int sum = 0;
      for (int i = 1; i <= 22; i++) sum += int'(f[i]);
      f.push_back(8'(sum % 256));
    end
`endif
    return f;
  endfunction

  // Model: a frame is just a queue of bytes popped on each accepted handshake.
  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) rx_log.push_back(tx_data);
    m_was_done = m_done;
    m_done = 0;
    if (rst) begin
      m_active = 0;
      m_q.delete();
    end else if (m_active) begin
      if (tx_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_active = 0;
          m_done = 1;
        end
      end
    end else if (start && !m_was_done) begin
      m_q = build_frame(channel_select, aline_select, pulse_shape, delays);
      m_active = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_valid", tx_valid, m_active);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      if (m_active) chk("tx_data", tx_data, m_q[0]);
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    bit got = 0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("wait_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_log(input string name, input byte_q_t exp);
    chk({name, "_len"}, rx_log.size(), exp.size());
    if (rx_log.size() == exp.size())
      for (int i = 0; i < exp.size(); i++) chk($sformatf("%s_b%0d", name, i), rx_log[i], exp[i]);
  endtask

  task automatic set_basic();
    channel_select = 8'h1B;
    aline_select   = 5'h03;
    pulse_shape    = 32'hDEADBEEF;
    delays         = '0;
  endtask

  byte_q_t lit;
  int      cyc;
  logic [127:0] dtmp;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    lit = '{8'hA5, 8'h1B, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 16; i++) lit.push_back(8'h00);
`ifdef CONFIG_READBACK_CHECKSUM_EN
    lit.push_back(8'h56);
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk_en = 1;
    tick();
    rst = 1'b0;
    tick();

    // Model pinned against hand-computed frame
    begin
      byte_q_t mf = build_frame(8'h1B, 5'h03, 32'hDEADBEEF, '0);
      chk_log("model_pin_len_only", '{}); // rx_log empty here
      chk("model_len", mf.size(), FRAME_LEN);
      chk("model_b4", mf[4], 8'hAD);
`ifdef CONFIG_READBACK_CHECKSUM_EN
      chk("model_csum", mf[23], 8'h56);
`endif
    end

    // Basic frame
    set_basic();
    tx_ready = 1'b1;
    rx_log.delete();
    done_cnt = 0;
    pulse_start();
    wait_done(100, cyc);
    chk("basic_latency", cyc, FRAME_LEN + 1);
    chk_log("basic", lit);

    // start during DONE is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("done_start_ignored", busy, 1'b0);
    tick();

    // Backpressure on byte 4
    rx_log.delete();
    pulse_start();
    repeat (4) tick();
    tx_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_data", tx_data, 8'hAD);
      chk("bp_hold_valid", tx_valid, 1'b1);
      tick();
    end
    tx_ready = 1'b1;
    wait_done(100, cyc);
    chk_log("bp", lit);
    tick();

    // Snapshot isolation
    rx_log.delete();
    pulse_start();
    tick();
    pulse_shape = 32'h12345678;
    wait_done(100, cyc);
    chk_log("snap", lit);
    tick();

    // Delay ordering
    dtmp = '0;
    dtmp[15:0]    = 16'h0102;
    dtmp[127:112] = 16'hF0E1;
    delays = dtmp;
    rx_log.delete();
    pulse_start();
    wait_done(100, cyc);
    chk("dly_len", rx_log.size(), FRAME_LEN);
    if (rx_log.size() == FRAME_LEN) begin
      chk("dly_b7", rx_log[7], 8'h01);
      chk("dly_b8", rx_log[8], 8'h02);
      chk("dly_b21", rx_log[21], 8'hF0);
      chk("dly_b22", rx_log[22], 8'hE1);
    end
    tick();

    // Extra start mid-frame
    set_basic();
    rx_log.delete();
    done_cnt = 0;
    pulse_start();
    repeat (5) tick();
    pulse_start();
    wait_done(100, cyc);
    repeat (3) tick();
    chk("ign_start_done_cnt", done_cnt, 1);
    chk_log("ign_start", lit);

    // Mid-frame reset at byte 10
    rx_log.delete();
    pulse_start();
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", tx_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_partial", rx_log.size(), 10);
    tick();

    // Back-to-back frames, second started the cycle after done
    rx_log.delete();
    pulse_start();
    wait_done(100, cyc);
    tick();
    pulse_start();
    wait_done(100, cyc);
    chk("b2b_latency", cyc, FRAME_LEN + 1);
    chk("b2b_bytes", rx_log.size(), 2 * FRAME_LEN);
    tick();

    // Randomized traffic
    for (int f = 0; f < 30; f++) begin
      channel_select = 8'($urandom);
      aline_select   = 5'($urandom);
      pulse_shape    = $urandom;
      delays         = {$urandom, $urandom, $urandom, $urandom};
      for (int c = 0; c < 50; c++) begin
        tx_ready = ($urandom_range(0, 3) != 0);
        start    = (c == 0) || ($urandom_range(0, 15) == 0);
        rst      = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 7) == 0) pulse_shape = $urandom;
        if ($urandom_range(0, 7) == 0) delays[31:0] = $urandom;
        tick();
      end
      start    = 1'b0;
      rst      = 1'b0;
      tx_ready = 1'b1;
      repeat (30) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
